rv32_mem_arbiter: RTL
=====================

# rv32_mem_arbiter

Shares one 32-bit memory bus between the instruction-fetch port and the data (mem-stage) port. Grant changes only at transaction boundaries. Each granted access passes combinationally onto the bus. Per-port ready signals feed the hazard unit, which stalls a stage until its access completes. The block sits between `rv32_fetch`/mem stage and the single external bus.

## Interface
- No parameters.
- `clk`  in  1  clock
- `reset`  in  1  asynchronous reset, active-high
- `instr_read_in`  in  1  fetch requests a read
- `instr_address_in`  in  32  fetch address
- `instr_ready_out`  out  1  fetch access completes this cycle
- `instr_read_value_out`  out  32  fetch read data, valid with `instr_ready_out`
- `data_read_in`  in  1  mem stage requests a read
- `data_write_in`  in  1  mem stage requests a write
- `data_address_in`  in  32  data address
- `data_write_mask_in`  in  4  byte enables for writes
- `data_write_value_in`  in  32  write data
- `data_ready_out`  out  1  data access completes this cycle
- `data_read_value_out`  out  32  data read data, valid with `data_ready_out`
- `bus_valid_out`  out  1  bus transaction active
- `bus_write_out`  out  1  1 = write, 0 = read
- `bus_address_out`  out  32  bus address
- `bus_write_mask_out`  out  4  byte enables, 0 on reads
- `bus_write_value_out`  out  32  write data
- `bus_read_value_in`  in  32  read data
- `bus_ready_in`  in  1  slave accepts/completes the transaction this cycle

## Operation
- Single registered `grant` ∈ {INSTR, DATA}. The grant holder is "parked" on the bus.
- Request signals:
  - `instr_req = instr_read_in`
  - `data_req = data_read_in | data_write_in`
- Bus outputs come combinationally from the holder:
  - `bus_valid_out` = holder's request.
  - Address, write, mask and value come from the holder. INSTR drives write=0, mask=0, value=0.
- Completion is `bus_valid_out & bus_ready_in`.
  - `instr_ready_out` = completion & grant==INSTR.
  - `data_ready_out` = completion & grant==DATA.
  - A port that is not granted always sees ready=0.
- `bus_read_value_in` is routed to both `*_read_value_out` unconditionally. Consumers qualify it with their ready signal.
- Re-arbitration happens at a clock edge only when the holder is idle (request=0) or completing. Otherwise `grant` holds. A switch never occurs mid-transaction.
- Winner on re-arbitration:
  - Only one port requesting: that port.
  - Neither requesting: keep current grant.
  - Both requesting: DATA (fixed priority; see Configuration).
- `data_read_in & data_write_in` together is illegal. The arbiter treats it as a write.
- Requesters hold address, data and request stable until they see ready.

## Timing
- Reset (async): `grant`=INSTR, `last_winner`=INSTR.
- While reset is asserted, outputs follow the INSTR mux:
  - `bus_valid_out`=`instr_read_in`, `bus_write_out`=0, `bus_write_mask_out`=0, `bus_write_value_out`=0.
  - `data_ready_out`=0.
  - Ready outputs are forced to 0 during reset.
- Granted port with a zero-wait-state slave: request → bus in the same cycle, ready in the same cycle. Back-to-back accesses issue every cycle.
- Non-granted port waits for the holder to complete. It is granted at the next edge and its earliest ready comes 1 cycle after the holder's completion.
- Wait states: `bus_ready_in`=0 holds all bus outputs and grant unchanged indefinitely.
- Reset mid-transaction: the transaction is abandoned and grant returns to INSTR immediately. The slave sees `bus_valid_out` follow fetch.

## Configuration
- `RV32_ARB_ROUND_ROBIN_EN`
  - Defined: a 1-bit `last_winner` register records the port granted at each re-arbitration. When both ports request, the port that is not `last_winner` wins, so the ports alternate under contention.
  - Undefined: fixed DATA priority. `last_winner` is not implemented.
  - Single-requester and idle rules are identical in both builds.

## Test plan
- Reset with `instr_read_in`=1, addr 0x00000000, `bus_ready_in`=1: after release, `instr_ready_out`=1 every cycle. Bus addresses 0x0, 0x4, 0x8 appear on consecutive cycles and `data_ready_out`=0.
- Grant INSTR; data read 0x1000 asserted while fetch 0x20 is waiting (`bus_ready_in`=0 for 3 cycles): bus shows 0x20 throughout. Then check:
  - After `instr_ready_out`, the next cycle bus shows 0x1000 with write=0.
  - `data_ready_out`=1 with `data_read_value_out`=0xDEADBEEF.
- Data write 0x2000, mask 0b0011, value 0x12345678: the bus carries exactly these with `bus_write_out`=1. `instr_ready_out` stays 0 until the write completes.
- Both ports requesting continuously, `bus_ready_in`=1:
  - Without the macro: DATA is granted on every re-arbitration.
  - With `RV32_ARB_ROUND_ROBIN_EN`: grants alternate DATA, INSTR, DATA, INSTR.
- Reset asserted mid-way through a 4-wait-state data write: `bus_write_out` drops to 0 asynchronously, grant returns to INSTR, and no ready pulse is issued.
- `data_read_in`=`data_write_in`=1 at address 0x3000: the bus performs a write (`bus_write_out`=1).

Source files
------------

// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one 32-bit memory bus between fetch and mem stage.
// Optional build macro RV32_ARB_ROUND_ROBIN_EN selects alternating priority.
module rv32_mem_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        instr_read_in,
    input  logic [31:0] instr_address_in,
    output logic        instr_ready_out,
    output logic [31:0] instr_read_value_out,

    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [31:0] data_address_in,
    input  logic [3:0]  data_write_mask_in,
    input  logic [31:0] data_write_value_in,
    output logic        data_ready_out,
    output logic [31:0] data_read_value_out,

    output logic        bus_valid_out,
    output logic        bus_write_out,
    output logic [31:0] bus_address_out,
    output logic [3:0]  bus_write_mask_out,
    output logic [31:0] bus_write_value_out,
    input  logic [31:0] bus_read_value_in,
    input  logic        bus_ready_in
);

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    grant_t grant;
    grant_t next_grant;

    logic instr_req;
    logic data_req;
    logic complete;
    logic rearb;
    logic contend;
    logic only_data;
    logic only_instr;

    assign instr_req = instr_read_in;
    assign data_req  = data_read_in | data_write_in;

    assign contend    = instr_req & data_req;
    assign only_data  = data_req & ~instr_req;
    assign only_instr = instr_req & ~data_req;

    // Steer the current holder's transaction onto the bus
    always_comb begin
        bus_valid_out       = instr_req;
        bus_write_out       = 1'b0;
        bus_address_out     = instr_address_in;
        bus_write_mask_out  = 4'b0000;
        bus_write_value_out = 32'h0000_0000;
        if (grant == GRANT_DATA) begin
            bus_valid_out       = data_req;
            bus_write_out       = data_write_in;
            bus_address_out     = data_address_in;
            bus_write_mask_out  = data_write_in ? data_write_mask_in : 4'b0000;
            bus_write_value_out = data_write_value_in;
        end
    end

    assign complete = bus_valid_out & bus_ready_in;

    // A held transaction is never split; only idle or finishing holders yield
    assign rearb = ~bus_valid_out | complete;

    assign instr_ready_out = complete & (grant == GRANT_INSTR) & ~reset;
    assign data_ready_out  = complete & (grant == GRANT_DATA) & ~reset;

    assign instr_read_value_out = bus_read_value_in;
    assign data_read_value_out  = bus_read_value_in;

`ifdef RV32_ARB_ROUND_ROBIN_EN

    grant_t last_winner;

    // Pick the next holder; under contention the previous loser wins
    always_comb begin
        next_grant = grant;
        unique case (1'b1)
            contend:
                next_grant = (last_winner == GRANT_DATA) ?
                             GRANT_INSTR : GRANT_DATA;
            only_data:  next_grant = GRANT_DATA;
            only_instr: next_grant = GRANT_INSTR;
            default:    next_grant = grant;
        endcase
    end

    // Grant and last-winner registers, updated only at re-arbitration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant       <= GRANT_INSTR;
            last_winner <= GRANT_INSTR;
        end else if (rearb) begin
            grant       <= next_grant;
            last_winner <= next_grant;
        end
    end

`else

    // Pick the next holder; the mem stage wins under contention
    always_comb begin
        next_grant = grant;
        unique case (1'b1)
            contend:    next_grant = GRANT_DATA;
            only_data:  next_grant = GRANT_DATA;
            only_instr: next_grant = GRANT_INSTR;
            default:    next_grant = grant;
        endcase
    end

    // Grant register, updated only at re-arbitration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant <= GRANT_INSTR;
        end else if (rearb) begin
            grant <= next_grant;
        end
    end

`endif

endmodule
